// File: rtl/fifo_pack_drain.sv
// Pops narrow words from a registered-read FIFO and packs RATIO of them, LSB first, into one wide word.
// Latency: RATIO+1 cycles from the first read enable to out_valid_o; one word per RATIO+2 cycles when unstalled.
// Backpressure: the packed word is held stable and no reads are issued until out_ready_i accepts it.
//
// Ports:
//   clk_i, rst_i              clock (rising edge) and synchronous active-low reset
//   fifo_rdata_i/_empty_i     FIFO read data (valid the cycle after a pop) and empty flag
//   fifo_rd_en_o              FIFO pop request
//   flush_i                   request to emit a partially filled word
//   out_data_o/_cnt_o         packed word and number of valid slots in it
//   out_valid_o/out_ready_i   output handshake
module fifo_pack_drain #(
  parameter int WIDTH     = 4,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = WIDTH * RATIO
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [WIDTH-1:0]             fifo_rdata_i,
  input  logic                         fifo_empty_i,
  output logic                         fifo_rd_en_o,
  input  logic                         flush_i,
  output logic [OUT_WIDTH-1:0]         out_data_o,
  output logic [$clog2(RATIO+1)-1:0]   out_cnt_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam int CW = $clog2(RATIO+1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        captured;
  logic                 pend;        // a read issued last edge; its data is on fifo_rdata_i now
  logic                 flush_pend;
  logic [OUT_WIDTH-1:0] slots;
  logic [OUT_WIDTH-1:0] slots_nxt;

  logic last_fill;   // the in-flight word completes the packed word this edge
  logic flush_take;  // flush_i accepted this cycle
  logic flush_done;  // partial word can be emitted this edge

  always_comb begin
    slots_nxt = slots;
    if (pend) begin
      slots_nxt[int'(captured)*WIDTH +: WIDTH] = fifo_rdata_i;
    end
  end

  assign last_fill  = (state_q == FILL) && pend && (captured == CW'(RATIO-1));
  // A flush arriving with the final slot filling is absorbed by the full word.
  assign flush_take = (state_q == FILL) && flush_i && !flush_pend &&
                      ((captured != '0) || pend) && !last_fill;
  assign flush_done = (state_q == FILL) && flush_pend && !pend && (captured != '0);

  // flush_take also gates the read so no new word is popped in the flush cycle.
  assign fifo_rd_en_o = (state_q == FILL) && !fifo_empty_i && (issued < CW'(RATIO)) &&
                        !flush_pend && !flush_take;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (last_fill || flush_done) state_d = HOLD;
      HOLD: if (out_valid_o && out_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      issued      <= '0;
      captured    <= '0;
      pend        <= 1'b0;
      flush_pend  <= 1'b0;
      slots       <= '0;
      out_data_o  <= '0;
      out_cnt_o   <= '0;
      out_valid_o <= 1'b0;
    end else begin
      pend <= fifo_rd_en_o;
      if (fifo_rd_en_o) begin
        issued <= issued + 1'b1;
      end
      if (state_q == FILL) begin
        if (pend) begin
          slots    <= slots_nxt;
          captured <= captured + 1'b1;
        end
        if (flush_take) begin
          flush_pend <= 1'b1;
        end
        if (last_fill) begin
          out_data_o  <= slots_nxt;
          out_cnt_o   <= CW'(RATIO);
          out_valid_o <= 1'b1;
          slots       <= '0;
          issued      <= '0;
          captured    <= '0;
          flush_pend  <= 1'b0;
        end else if (flush_done) begin
          // Unfilled upper slots are already zero since slots is cleared on every emit.
          out_data_o  <= slots;
          out_cnt_o   <= captured;
          out_valid_o <= 1'b1;
          slots       <= '0;
          issued      <= '0;
          captured    <= '0;
          flush_pend  <= 1'b0;
        end
      end else begin
        if (out_ready_i) begin
          out_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_pack_drain.sv
// Self-checking bench for fifo_pack_drain with a behavioural registered-read FIFO
// and a scoreboard of expected packed words.
module tb_fifo_pack_drain;

  localparam int WIDTH = 4;
  localparam int RATIO = 4;
  localparam int OW    = WIDTH * RATIO;
  localparam int CW    = $clog2(RATIO+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_valid;
  logic          out_ready = 1'b1;

  fifo_pack_drain #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_rdata_i (fifo_rdata),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .flush_i      (flush),
    .out_data_o   (out_data),
    .out_cnt_o    (out_cnt),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read, empty flag follows the pop edge.
  logic [WIDTH-1:0] mem [0:255];
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  logic rd_en_s = 1'b0;
  logic underflow = 1'b0;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rd_en_s) begin
      if (wr_cnt == rd_cnt) begin
        underflow <= 1'b1;
      end else begin
        fifo_rdata <= mem[rd_cnt % 256];
        rd_cnt     <= rd_cnt + 1;
      end
    end
  end

  // Scoreboard and statistics.
  logic [OW-1:0] exp_d [$];
  logic [CW-1:0] exp_c [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int vld_cycles = 0;
  int acc = 0;
  int t_rd = -1;
  int t_vld = -1;
  logic hold_prev = 1'b0;
  logic [OW-1:0] prev_d = '0;
  logic [CW-1:0] prev_c = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [OW-1:0] ed;
    logic [CW-1:0] ec;
    cyc++;
    rd_en_s = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_pulses++;
      if (t_rd < 0) t_rd = cyc;
    end
    if (out_valid) begin
      vld_cycles++;
      if (t_vld < 0) t_vld = cyc;
      check("rd_in_hold", {31'd0, fifo_rd_en}, 32'd0);
    end
    if (hold_prev) begin
      check("stable_dat", {16'd0, out_data}, {16'd0, prev_d});
      check("stable_cnt", {29'd0, out_cnt}, {29'd0, prev_c});
      check("stable_vld", {31'd0, out_valid}, 32'd1);
    end
    hold_prev = out_valid && !out_ready;
    prev_d    = out_data;
    prev_c    = out_cnt;
    if (out_valid && out_ready) begin
      acc++;
      check("pending_exp", {31'd0, exp_d.size() != 0}, 32'd1);
      if (exp_d.size() != 0) begin
        ed = exp_d.pop_front();
        ec = exp_c.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, ed});
        check("out_cnt", {29'd0, out_cnt}, {29'd0, ec});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wr_cnt % 256] = w;
    wr_cnt++;
  endtask

  task automatic expect_word(input logic [OW-1:0] d, input logic [CW-1:0] c);
    exp_d.push_back(d);
    exp_c.push_back(c);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_d.size() != 0; i++) step();
    check("drain_timeout", exp_d.size(), 32'd0);
  endtask

  int base;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_cnt", {29'd0, out_cnt}, 32'd0);
    check("rst_rden", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b1;
    step();

    // Single packed word, latency and single-cycle valid
    base = rd_pulses; t_rd = -1; t_vld = -1; vld_cycles = 0;
    for (int i = 1; i <= 4; i++) push_word(WIDTH'(i));
    expect_word(16'h4321, 3'd4);
    wait_drain(40);
    repeat (2) step();
    check("t1_rd_pulses", rd_pulses - base, 32'd4);
    check("t1_latency", t_vld - t_rd, RATIO + 1);
    check("t1_vld_cycles", vld_cycles, 32'd1);

    // Sixteen words streamed
    base = rd_pulses;
    for (int i = 0; i < 16; i++) push_word(WIDTH'(i));
    expect_word(16'h3210, 3'd4);
    expect_word(16'h7654, 3'd4);
    expect_word(16'hBA98, 3'd4);
    expect_word(16'hFEDC, 3'd4);
    wait_drain(100);
    repeat (2) step();
    check("t2_rd_pulses", rd_pulses - base, 32'd16);
    check("t2_empty", {31'd0, fifo_empty}, 32'd1);
    check("t2_underflow", {31'd0, underflow}, 32'd0);

    // Backpressure with eight words queued
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    for (int i = 0; i < 40 && !out_valid; i++) step();
    check("bp_vld_timeout", {31'd0, out_valid}, 32'd1);
    base = rd_pulses;
    repeat (6) step();
    check("bp_no_reads", rd_pulses - base, 32'd0);
    check("bp_held_data", {16'd0, out_data}, 32'h4321);
    out_ready = 1'b1;
    wait_drain(60);
    repeat (2) step();

    // Flush a two-word partial, then a flush with nothing captured
    push_word(4'hA);
    push_word(4'hB);
    repeat (6) step();
    check("fl_no_early_out", {31'd0, out_valid}, 32'd0);
    expect_word(16'h00BA, 3'd2);
    flush = 1'b1; step(); flush = 1'b0;
    wait_drain(20);
    repeat (2) step();
    base = acc;
    flush = 1'b1; step(); flush = 1'b0;
    repeat (6) step();
    check("fl_empty_ignored", acc - base, 32'd0);

    // Flush the cycle after the third read enable
    base = rd_pulses;
    for (int i = 1; i <= 4; i++) push_word(WIDTH'(i));
    for (int i = 0; i < 30 && rd_pulses < base + 3; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    expect_word(16'h0321, 3'd3);
    wait_drain(20);
    check("fl_no_4th_read", rd_pulses - base, 32'd3);
    // The leftover fourth word is read after the handshake and flushed alone.
    expect_word(16'h0004, 3'd1);
    repeat (4) step();
    flush = 1'b1; step(); flush = 1'b0;
    wait_drain(20);
    repeat (2) step();

    // Reset after two captures
    base = rd_pulses;
    push_word(4'h1);
    push_word(4'h2);
    for (int i = 0; i < 30 && rd_pulses < base + 2; i++) step();
    repeat (2) step();
    check("rs_no_out", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    step();
    check("rs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_data", {16'd0, out_data}, 32'd0);
    check("rs_cnt", {29'd0, out_cnt}, 32'd0);
    check("rs_rden", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b1;
    step();
    for (int i = 5; i <= 8; i++) push_word(WIDTH'(i));
    expect_word(16'h8765, 3'd4);
    wait_drain(40);
    repeat (2) step();
    check("end_underflow", {31'd0, underflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
